// File: rtl/cpu_clock_contention.sv
// Z80 clock generator: divides the 14 MHz ULA clock by 4 (or 2 in turbo) and
// stretches the low phase during video RAM contention using the 48K delay pattern.
module cpu_clock_contention #(
  parameter logic [31:0] DELAY_TABLE = 32'h0012_3456,
  parameter int          STAT_W      = 16
) (
  input  logic              clk_ula,
  input  logic              reset,
  input  logic              turbo,
  input  logic              contend_en,
  input  logic              display_active,
  input  logic              tstate_sync,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_mreq_n,
  input  logic              cpu_iorq_n,
  output logic              clk_cpu,
  output logic              cpu_tick,
  output logic              stall,
  output logic [STAT_W-1:0] stall_total
);

  localparam logic [1:0]        PRESC_LAST = 2'd3;
  localparam logic [STAT_W-1:0] STAT_ONE   = {{(STAT_W-1){1'b0}}, 1'b1};
  localparam logic [STAT_W-1:0] STAT_MAX   = {STAT_W{1'b1}};

  logic [1:0]        presc_q,     presc_d;
  logic [2:0]        tphase_q,    tphase_d;
  logic [3:0]        stall_cnt_q, stall_cnt_d;
  logic              granted_q,   granted_d;
  logic              clk_cpu_q,   clk_cpu_d;
  logic              tick_q,      tick_d;
  logic              stall_q,     stall_d;
  logic [STAT_W-1:0] total_q,     total_d;

  logic       at_last;
  logic       ula_page;
  logic       mem_hit;
  logic       io_hit;
  logic       contended;
  logic       hold;
  logic [3:0] delay;

  // Address decode: 0x4000-0x7FFF is shared with the ULA; even I/O ports hit the ULA too.
  always_comb begin
    ula_page  = (cpu_addr[15:14] == 2'b01);
    mem_hit   = !cpu_mreq_n && ula_page;
    io_hit    = !cpu_iorq_n && (ula_page || !cpu_addr[0]);
    contended = contend_en && display_active && !turbo && (mem_hit || io_hit);
    at_last   = (presc_q == PRESC_LAST);
    delay     = DELAY_TABLE[{tphase_q, 2'b00} +: 4];
  end

  always_comb begin
    presc_d  = tstate_sync ? 2'd0 : presc_q + 2'd1;
    tphase_d = tstate_sync ? 3'd0 : (at_last ? tphase_q + 3'd1 : tphase_q);

    stall_cnt_d = stall_cnt_q;
    granted_d   = granted_q;
    total_d     = total_q;
    if (turbo) begin
      stall_cnt_d = 4'd0;
    end else if (at_last) begin
      if (stall_cnt_q != 4'd0) begin
        stall_cnt_d = stall_cnt_q - 4'd1;
        if (total_q != STAT_MAX) total_d = total_q + STAT_ONE;
      end else if (!granted_q && contended) begin
        granted_d   = 1'b1;
        stall_cnt_d = delay;
      end
    end
    // Bus idle at a T-state boundary re-arms contention for the next access.
    if (at_last && cpu_mreq_n && cpu_iorq_n) granted_d = 1'b0;

    hold = (stall_cnt_d != 4'd0);

    // Normal mode derives the level from the prescaler so leaving turbo resyncs cleanly.
    if (turbo)
      clk_cpu_d = !clk_cpu_q;
    else
      clk_cpu_d = !hold && ((presc_d == 2'd0) || (presc_d == 2'd1 && clk_cpu_q));

    tick_d  = clk_cpu_d && !clk_cpu_q;
    stall_d = hold;
  end

  always_ff @(posedge clk_ula) begin
    if (reset) begin
      presc_q     <= 2'd0;
      tphase_q    <= 3'd0;
      stall_cnt_q <= 4'd0;
      granted_q   <= 1'b0;
      clk_cpu_q   <= 1'b0;
      tick_q      <= 1'b0;
      stall_q     <= 1'b0;
      total_q     <= '0;
    end else begin
      presc_q     <= presc_d;
      tphase_q    <= tphase_d;
      stall_cnt_q <= stall_cnt_d;
      granted_q   <= granted_d;
      clk_cpu_q   <= clk_cpu_d;
      tick_q      <= tick_d;
      stall_q     <= stall_d;
      total_q     <= total_d;
    end
  end

  assign clk_cpu     = clk_cpu_q;
  assign cpu_tick    = tick_q;
  assign stall       = stall_q;
  assign stall_total = total_q;

endmodule
